// File: rtl/xbar_rx_pkg.sv
// Shared types for the per-node crossbar receive endpoint.
// Defines the fabric message format, node IDs and the slot-to-source mapping.
package xbar_rx_pkg;

  localparam int NUM_CPUS = 4;

  typedef struct packed {
    logic        valid;
    logic [3:0]  opcode;
    logic [15:0] addr;
    logic [31:0] data;
  } xbar_msg_t;

  typedef logic [$clog2(NUM_CPUS+1)-1:0] node_id_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_HOLD
  } arb_state_t;

  // A node never sends to itself, so slots at or above our own ID shift up by one.
  function automatic node_id_t slot_to_src(input int slot, input int nodeId);
    return (slot >= nodeId) ? node_id_t'(slot + 1) : node_id_t'(slot);
  endfunction

endpackage

// File: rtl/xbar_rx_fifo.sv
// Per-source synchronous FIFO for crossbar messages.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module xbar_rx_fifo
  import xbar_rx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  xbar_msg_t                  din,
  output xbar_msg_t                  head,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  xbar_msg_t        r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign w_doPop  = pop & ~empty;
  assign w_doPush = push & (~full | w_doPop);

  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= din;
    end
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      unique case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head  = r_mem[r_rdPtr];
  assign empty = (r_count == '0);
  assign full  = (r_count == CNT_W'(DEPTH));
  assign count = r_count;

endmodule

// File: rtl/xbar_rx.sv
// Crossbar receive endpoint: buffers each source slot in its own FIFO and
// presents buffered messages one at a time through a round-robin arbiter.
module xbar_rx
  import xbar_rx_pkg::*;
#(
  parameter int NODE_ID    = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  xbar_msg_t           rx_in [NUM_CPUS],
  output logic                msg_valid,
  input  logic                msg_ready,
  output xbar_msg_t           msg_out,
  output node_id_t            msg_src,
  output logic                overflow,
  output logic [NUM_CPUS-1:0] overflow_src
);

  localparam int SLOT_W = (NUM_CPUS > 1) ? $clog2(NUM_CPUS) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH+1);

  typedef logic [SLOT_W-1:0] slot_t;

  arb_state_t          r_state;
  arb_state_t          w_nextState;
  slot_t               r_grant;
  slot_t               w_nextGrant;
  slot_t               r_rrPtr;
  slot_t               w_nextPtr;
  slot_t               w_grantInc;
  slot_t               w_base;
  slot_t               w_idx;
  slot_t               w_cand;
  logic                w_found;
  logic                w_handshake;
  logic                r_overflow;
  logic [NUM_CPUS-1:0] r_overflowSrc;
  logic [NUM_CPUS-1:0] w_pop;
  logic [NUM_CPUS-1:0] w_empty;
  logic [NUM_CPUS-1:0] w_full;
  logic [NUM_CPUS-1:0] w_avail;
  logic [NUM_CPUS-1:0] w_drop;
  xbar_msg_t           w_head  [NUM_CPUS];
  logic [CNT_W-1:0]    w_count [NUM_CPUS];
  node_id_t            w_srcId [NUM_CPUS];

  for (genvar j = 0; j < NUM_CPUS; j++) begin : g_slot
    assign w_srcId[j] = slot_to_src(j, NODE_ID);
    assign w_drop[j]  = rx_in[j].valid & w_full[j] & ~w_pop[j];

    xbar_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rx_in[j].valid),
      .pop   (w_pop[j]),
      .din   (rx_in[j]),
      .head  (w_head[j]),
      .empty (w_empty[j]),
      .full  (w_full[j]),
      .count (w_count[j])
    );
  end

  // Re-arbitration on a handshake sees post-pop occupancy but not this cycle's pushes.
  always_comb begin
    w_handshake = (r_state == ARB_HOLD) && msg_ready;
    w_grantInc  = (r_grant == slot_t'(NUM_CPUS-1)) ? '0 : r_grant + 1'b1;
    w_avail     = ~w_empty;
    if (w_handshake && (w_count[r_grant] <= CNT_W'(1))) begin
      w_avail[r_grant] = 1'b0;
    end
    w_base  = w_handshake ? w_grantInc : r_rrPtr;
    w_found = 1'b0;
    w_cand  = w_base;
    w_idx   = w_base;
    for (int k = NUM_CPUS-1; k >= 0; k--) begin
      w_idx = slot_t'((int'(w_base) + k) % NUM_CPUS);
      if (w_avail[w_idx]) begin
        w_found = 1'b1;
        w_cand  = w_idx;
      end
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextGrant = r_grant;
    w_nextPtr   = r_rrPtr;
    w_pop       = '0;
    case (r_state)
      ARB_IDLE: begin
        if (w_found) begin
          w_nextState = ARB_HOLD;
          w_nextGrant = w_cand;
        end
      end
      ARB_HOLD: begin
        if (msg_ready) begin
          w_pop[r_grant] = 1'b1;
          w_nextPtr      = w_grantInc;
          if (w_found) begin
            w_nextGrant = w_cand;
          end else begin
            w_nextState = ARB_IDLE;
          end
        end
      end
      default: w_nextState = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ARB_IDLE;
      r_grant       <= '0;
      r_rrPtr       <= '0;
      r_overflow    <= 1'b0;
      r_overflowSrc <= '0;
    end else begin
      r_state       <= w_nextState;
      r_grant       <= w_nextGrant;
      r_rrPtr       <= w_nextPtr;
      r_overflow    <= r_overflow | (|w_drop);
      r_overflowSrc <= r_overflowSrc | w_drop;
    end
  end

  assign msg_valid    = (r_state == ARB_HOLD);
  assign msg_out      = msg_valid ? w_head[r_grant] : '0;
  assign msg_src      = msg_valid ? w_srcId[r_grant] : '0;
  assign overflow     = r_overflow;
  assign overflow_src = r_overflowSrc;

endmodule

// File: tb/tb_xbar_rx.sv
// Directed self-checking bench for xbar_rx with NUM_CPUS=4, NODE_ID=2, FIFO_DEPTH=4.
// Slots 0,1,2,3 map to source nodes 0,1,3,4.
module tb_xbar_rx;
  import xbar_rx_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  xbar_msg_t           rx_in [NUM_CPUS];
  logic                msg_valid;
  logic                msg_ready;
  xbar_msg_t           msg_out;
  node_id_t            msg_src;
  logic                overflow;
  logic [NUM_CPUS-1:0] overflow_src;

  int numChecks = 0;
  int numFails  = 0;

  always #5 clk = ~clk;

  xbar_rx #(.NODE_ID(2), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_in        (rx_in),
    .msg_valid    (msg_valid),
    .msg_ready    (msg_ready),
    .msg_out      (msg_out),
    .msg_src      (msg_src),
    .overflow     (overflow),
    .overflow_src (overflow_src)
  );

  function automatic xbar_msg_t mkMsg(input int slot, input logic [31:0] tag);
    xbar_msg_t m;
    m.valid  = 1'b1;
    m.opcode = 4'(slot);
    m.addr   = tag[15:0];
    m.data   = {tag[15:0], 16'hBEEF};
    return m;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
    numChecks++;
    assert (obs === exp) else begin
      numFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Drive one cycle of arrivals/ready, clock once, then sample 1ns after the edge.
  task automatic applyStimulus(input logic [3:0] mask, input logic ready, input logic [31:0] tag);
    for (int j = 0; j < NUM_CPUS; j++) begin
      rx_in[j] = mask[j] ? mkMsg(j, tag) : '0;
    end
    msg_ready = ready;
    @(posedge clk);
    #1;
    for (int j = 0; j < NUM_CPUS; j++) begin
      rx_in[j] = '0;
    end
  endtask

  task automatic applyReset();
    rst       = 1'b1;
    msg_ready = 1'b0;
    for (int j = 0; j < NUM_CPUS; j++) begin
      rx_in[j] = '0;
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic checkAllIdle(input string pfx);
    checkOutput({pfx, "_valid"}, 64'(msg_valid), 64'(0));
    checkOutput({pfx, "_out"}, 64'(msg_out), 64'(0));
    checkOutput({pfx, "_src"}, 64'(msg_src), 64'(0));
    checkOutput({pfx, "_ovf"}, 64'(overflow), 64'(0));
    checkOutput({pfx, "_ovfsrc"}, 64'(overflow_src), 64'(0));
  endtask

  initial begin
    int expSrc [4] = '{0, 1, 3, 4};

    applyReset();
    applyReset();
    checkAllIdle("reset");

    // Single message on slot 2 (source 3): visible two cycles after arrival.
    applyStimulus(4'b0100, 1'b1, 32'hA1);
    checkOutput("single_n1_valid", 64'(msg_valid), 64'(0));
    applyStimulus(4'b0000, 1'b1, 32'h0);
    checkOutput("single_n2_valid", 64'(msg_valid), 64'(1));
    checkOutput("single_n2_src", 64'(msg_src), 64'(3));
    checkOutput("single_n2_out", 64'(msg_out), 64'(mkMsg(2, 32'hA1)));
    applyStimulus(4'b0000, 1'b1, 32'h0);
    checkOutput("single_n3_valid", 64'(msg_valid), 64'(0));

    // Fan-in burst from rr_ptr=0.
    applyReset();
    applyStimulus(4'b1111, 1'b1, 32'hB2);
    checkOutput("fanin_push_valid", 64'(msg_valid), 64'(0));
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b0000, 1'b1, 32'h0);
      checkOutput("fanin_valid", 64'(msg_valid), 64'(1));
      checkOutput("fanin_src", 64'(msg_src), 64'(expSrc[i]));
      checkOutput("fanin_out", 64'(msg_out), 64'(mkMsg(i, 32'hB2)));
    end
    applyStimulus(4'b0000, 1'b1, 32'h0);
    checkOutput("fanin_end_valid", 64'(msg_valid), 64'(0));

    // Overflow on slot 0 with the consumer stalled.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b0001, 1'b0, 32'h10 + 32'(i));
    end
    checkOutput("ovf_before", 64'(overflow), 64'(0));
    applyStimulus(4'b0001, 1'b0, 32'h14);
    checkOutput("ovf_set", 64'(overflow), 64'(1));
    checkOutput("ovf_src_set", 64'(overflow_src), 64'(4'b0001));
    checkOutput("ovf_head", 64'(msg_out), 64'(mkMsg(0, 32'h10)));
    checkOutput("ovf_head_src", 64'(msg_src), 64'(0));
    for (int i = 1; i < 4; i++) begin
      applyStimulus(4'b0000, 1'b1, 32'h0);
      checkOutput("ovf_drain_out", 64'(msg_out), 64'(mkMsg(0, 32'h10 + 32'(i))));
    end
    applyStimulus(4'b0000, 1'b1, 32'h0);
    checkOutput("ovf_drain_end", 64'(msg_valid), 64'(0));
    checkOutput("ovf_sticky", 64'(overflow), 64'(1));
    checkOutput("ovf_src_sticky", 64'(overflow_src), 64'(4'b0001));

    // Full FIFO on slot 1: pop and push in the same cycle.
    applyReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b0010, 1'b0, 32'h20 + 32'(i));
    end
    checkOutput("full_valid", 64'(msg_valid), 64'(1));
    checkOutput("full_src", 64'(msg_src), 64'(1));
    checkOutput("full_head", 64'(msg_out), 64'(mkMsg(1, 32'h20)));
    applyStimulus(4'b0010, 1'b1, 32'h24);
    checkOutput("pp_ovf", 64'(overflow), 64'(0));
    checkOutput("pp_ovfsrc", 64'(overflow_src), 64'(0));
    checkOutput("pp_src", 64'(msg_src), 64'(1));
    checkOutput("pp_head", 64'(msg_out), 64'(mkMsg(1, 32'h21)));
    for (int i = 2; i < 5; i++) begin
      applyStimulus(4'b0000, 1'b1, 32'h0);
      checkOutput("pp_drain_out", 64'(msg_out), 64'(mkMsg(1, 32'h20 + 32'(i))));
    end
    applyStimulus(4'b0000, 1'b1, 32'h0);
    checkOutput("pp_drain_end", 64'(msg_valid), 64'(0));

    // Stall stability while other slots receive traffic.
    applyReset();
    applyStimulus(4'b0001, 1'b0, 32'h30);
    applyStimulus(4'b0000, 1'b0, 32'h0);
    checkOutput("stall_valid", 64'(msg_valid), 64'(1));
    checkOutput("stall_out0", 64'(msg_out), 64'(mkMsg(0, 32'h30)));
    applyStimulus(4'b1001, 1'b0, 32'h31);
    checkOutput("stall_out1", 64'(msg_out), 64'(mkMsg(0, 32'h30)));
    checkOutput("stall_src1", 64'(msg_src), 64'(0));
    applyStimulus(4'b1000, 1'b0, 32'h32);
    checkOutput("stall_out2", 64'(msg_out), 64'(mkMsg(0, 32'h30)));
    checkOutput("stall_src2", 64'(msg_src), 64'(0));
    applyStimulus(4'b1000, 1'b0, 32'h33);
    checkOutput("stall_out3", 64'(msg_out), 64'(mkMsg(0, 32'h30)));
    checkOutput("stall_src3", 64'(msg_src), 64'(0));
    applyStimulus(4'b0000, 1'b1, 32'h0);
    checkOutput("rr_next_src", 64'(msg_src), 64'(4));
    checkOutput("rr_next_out", 64'(msg_out), 64'(mkMsg(3, 32'h31)));

    // Build up three non-empty FIFOs plus an overflow, then reset mid-burst.
    applyStimulus(4'b0010, 1'b0, 32'h40);
    applyStimulus(4'b1000, 1'b0, 32'h41);
    applyStimulus(4'b1000, 1'b0, 32'h42);
    checkOutput("mid_ovf", 64'(overflow), 64'(1));
    checkOutput("mid_ovfsrc", 64'(overflow_src), 64'(4'b1000));
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkAllIdle("midrst");
    rst = 1'b0;
    applyStimulus(4'b0100, 1'b1, 32'h50);
    checkOutput("post_n1_valid", 64'(msg_valid), 64'(0));
    applyStimulus(4'b0000, 1'b1, 32'h0);
    checkOutput("post_n2_valid", 64'(msg_valid), 64'(1));
    checkOutput("post_n2_src", 64'(msg_src), 64'(3));
    checkOutput("post_n2_out", 64'(msg_out), 64'(mkMsg(2, 32'h50)));
    applyStimulus(4'b0000, 1'b1, 32'h0);
    checkOutput("post_n3_valid", 64'(msg_valid), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule

// File: doc/xbar_rx.md
# xbar_rx

Per-node receive endpoint for the crossbar fabric. It takes the `NUM_CPUS` messages delivered to one node each cycle, one from every other node, and buffers each source in its own FIFO. A round-robin arbiter then presents the buffered messages one at a time to the node's consumer (cache controller or memory controller) over a valid/ready handshake. The crossbar has no backpressure, so this block absorbs bursts and flags any overflow.

## Interface
Parameters:
- `NODE_ID`, default 0: this node's index, 0..`NUM_CPUS`; `NUM_CPUS` is the memory controller.
- `FIFO_DEPTH`, default 4: entries per source FIFO; must be a power of two and at least 2.

Ports:
- `clk` in 1: the block's single clock.
- `rst` in 1: synchronous, active-high reset.
- `rx_in` in `xbar_msg_t [NUM_CPUS]`: crossbar outputs for this node. Slot j carries source node `(j >= NODE_ID) ? j+1 : j`. A message is present when `rx_in[j].valid` = 1.
- `msg_valid` out 1: a buffered message is presented.
- `msg_ready` in 1: the consumer accepts the message this cycle.
- `msg_out` out `xbar_msg_t`: the presented message; all zeros when `msg_valid` = 0.
- `msg_src` out `node_id_t`: source node ID of `msg_out`; 0 when idle.
- `overflow` out 1: sticky flag; a message was dropped.
- `overflow_src` out `NUM_CPUS`: sticky per-slot drop mask.

## Operation
- Enqueue: slot j pushes `rx_in[j]` into FIFO j when `.valid` = 1.
  - There is no filtering; every valid message is stored.
- Overflow: a push into a FIFO that is full and not popped in the same cycle is dropped. This sets `overflow` and `overflow_src[j]`.
  - Only `rst` clears these flags.
- A push and a pop on a full FIFO in the same cycle are both accepted, with no overflow.
- Arbiter FSM states:
  - IDLE:
    - `msg_valid` = 0.
    - If any FIFO is non-empty, grant the first non-empty slot searching from `rr_ptr` upward, wrapping modulo `NUM_CPUS`.
    - Register the grant and go to HOLD.
  - HOLD:
    - `msg_valid` = 1; `msg_out` = head of the granted FIFO; `msg_src` = mapped ID of the granted slot.
    - The grant is locked until `msg_valid & msg_ready`.
    - On a handshake: pop the granted FIFO and set `rr_ptr` = grant+1 mod `NUM_CPUS`.
    - In the same cycle, re-arbitrate from the new `rr_ptr` using post-pop occupancy. The popped FIFO counts as non-empty only if its count was greater than 1.
    - If a candidate exists, stay in HOLD with the new grant; otherwise go to IDLE.
- Pushes in the handshake cycle are not visible to that re-arbitration.

## Timing
- Reset values: FIFOs empty, `rr_ptr` = 0, state IDLE, `msg_valid` = 0, `msg_out` = 0, `msg_src` = 0, `overflow` = 0, `overflow_src` = 0.
- Latency into an empty block: a message arriving in cycle N gives `msg_valid` = 1 in cycle N+2.
- Throughput: one message per cycle while `msg_ready` = 1 and any FIFO holds data.
- Stability: while `msg_valid` = 1 and `msg_ready` = 0, `msg_out` and `msg_src` hold constant, regardless of new arrivals.
- `msg_valid` never drops without a handshake.
- A reset asserted mid-burst discards all buffered data. All outputs take their reset values in the cycle after `rst` is sampled high.

## Structure
- `types` package:
  - reuse `NUM_CPUS` and `xbar_msg_t` (which includes the `valid` field);
  - add `node_id_t` = `logic [$clog2(NUM_CPUS+1)-1:0]`.
- Sub-module `xbar_rx_fifo`, instantiated once per slot:
  - synchronous FIFO of `xbar_msg_t`;
  - ports: `push`, `pop`, `head`, `empty`, `full`, `count`;
  - pop-and-push when full is legal.
- The top level holds the slot-to-source-ID mapping, the arbiter FSM, `rr_ptr` and the sticky flags.

## Test plan
Configuration: `NUM_CPUS` = 4, `NODE_ID` = 2, `FIFO_DEPTH` = 4.
- Single message: `rx_in[2]` valid in cycle 10, `msg_ready` = 1 → `msg_valid` = 1 in cycle 12 with `msg_src` = 3; `msg_valid` = 0 in cycle 13.
- Fan-in burst: all four slots valid in one cycle, `msg_ready` = 1 → four consecutive handshakes with `msg_src` = 0, 1, 3, 4, then `msg_valid` = 0.
- Overflow: `msg_ready` = 0 and 5 messages on slot 0 in consecutive cycles → `overflow` = 1 and `overflow_src` = 4'b0001 after the 5th. Then `msg_ready` = 1 → the first 4 messages drain in arrival order and the flags remain set.
- Full-FIFO pop+push: slot 1 full and presented; a handshake coincides with a new `rx_in[1]` → no overflow, and the count stays at 4.
- Stall stability: `msg_valid` = 1 with `msg_ready` = 0 for 3 cycles while `rx_in[3]` arrives → `msg_out` and `msg_src` unchanged. After the handshake, the next grant follows round-robin order.
- Reset mid-burst: assert `rst` with 3 FIFOs non-empty and `overflow` = 1 → next cycle all outputs are 0, and the next arrival again takes 2 cycles to `msg_valid`.
